// File: rtl/ib_vc_pkg.sv
// Shared flit type codes, FSM state type and flit-type helpers for the
// virtual-channel input buffer.
package ib_vc_pkg;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  // A flit may start a packet only if it is a head or head+tail.
  function automatic logic opens_pkt(input logic [1:0] ft);
    return (ft != FT_BODY) && (ft != FT_TAIL);
  endfunction

  function automatic logic closes_pkt(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_HT);
  endfunction

endpackage

// File: rtl/ib_fifo.sv
// Synchronous FIFO with a combinational front-of-queue output; one instance
// per virtual channel.
module ib_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rp];
  assign do_wr = we && !full;
  assign do_rd = re && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/ib_vc.sv
// Multi-VC switch input buffer: per-VC FIFOs, round-robin packet selection,
// one-hot output-port request and wormhole streaming under allocator ack.
module ib_vc
  import ib_vc_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int NPORT = 5,
  parameter int DSTW  = 3,
  parameter int NVC   = 2,
  parameter int VCW   = 1,
  parameter int DEPTH = 4,
  parameter int FLITW = 2 + DSTW + DATAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vi,
  input  logic [VCW-1:0]   vci,
  input  logic [FLITW-1:0] pkti,
  output logic [NVC-1:0]   full,
  input  logic             ack,
  output logic [NPORT-1:0] req,
  output logic             vo,
  output logic [FLITW-1:0] pkto,
  output logic [VCW-1:0]   vco,
  output logic             err
);

  logic [NVC-1:0]   empty;
  logic [NVC-1:0]   we;
  logic [NVC-1:0]   re;
  logic [FLITW-1:0] front [NVC];

  state_t         state;
  logic [VCW-1:0] sel;
  logic [VCW-1:0] ptr;
  logic [VCW-1:0] cand;
  logic [VCW-1:0] pop_vc;
  logic           found;
  logic           pop;
  logic           idle_drop;
  logic           wr_err;
  logic [1:0]     cand_ft;
  logic [DSTW-1:0] cand_dst;
  logic [1:0]     sel_ft;

  // Writes to a full FIFO are refused even if it pops this cycle.
  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign we[v] = vi && (int'(vci) == v) && !full[v];
    assign re[v] = pop && (int'(pop_vc) == v);

    ib_fifo #(.W(FLITW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .we    (we[v]),
      .re    (re[v]),
      .din   (pkti),
      .dout  (front[v]),
      .empty (empty[v]),
      .full  (full[v])
    );
  end

  assign wr_err = vi && ((int'(vci) >= NVC) || full[vci]);

  // Round-robin scan starting one past the last served VC.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NVC; i++) begin
      if (!found && !empty[(int'(ptr) + i) % NVC]) begin
        found = 1'b1;
        cand  = VCW'((int'(ptr) + i) % NVC);
      end
    end
  end

  assign cand_ft   = front[cand][FLITW-1 -: 2];
  assign cand_dst  = front[cand][DATAW +: DSTW];
  assign sel_ft    = front[sel][FLITW-1 -: 2];

  // A packet that cannot legally start is discarded one flit at a time.
  assign idle_drop = (state == ST_IDLE) && found &&
                     (!opens_pkt(cand_ft) || (int'(cand_dst) >= NPORT));

  assign vo     = (state == ST_XFER) && ack && !empty[sel];
  assign pkto   = vo ? front[sel] : '0;
  assign pop    = vo || idle_drop;
  assign pop_vc = (state == ST_XFER) ? sel : cand;

  // Packet-level FSM: choose a VC in IDLE, stream it in XFER until its tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= VCW'(NVC - 1);
      req   <= '0;
      vco   <= '0;
      err   <= 1'b0;
    end else begin
      if (wr_err) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (found) begin
            sel <= cand;
            ptr <= cand;
            vco <= cand;
            if (idle_drop) begin
              err <= 1'b1;
            end else begin
              req   <= NPORT'(1) << cand_dst;
              state <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (vo && closes_pkt(sel_ft)) begin
            req   <= '0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ib_vc.sv
// Directed bench for ib_vc: a queue-based packet model is compared with the
// DUT every cycle, plus hand-computed checks from the test plan.
module tb_ib_vc;

  localparam int DATAW = 32;
  localparam int NPORT = 5;
  localparam int DSTW  = 3;
  localparam int NVC   = 2;
  localparam int VCW   = 1;
  localparam int DEPTH = 4;
  localparam int FLITW = 2 + DSTW + DATAW;

  logic             clk;
  logic             rst;
  logic             vi;
  logic [VCW-1:0]   vci;
  logic [FLITW-1:0] pkti;
  logic [NVC-1:0]   full;
  logic             ack;
  logic [NPORT-1:0] req;
  logic             vo;
  logic [FLITW-1:0] pkto;
  logic [VCW-1:0]   vco;
  logic             err;

  ib_vc #(
    .DATAW(DATAW), .NPORT(NPORT), .DSTW(DSTW), .NVC(NVC),
    .VCW(VCW), .DEPTH(DEPTH), .FLITW(FLITW)
  ) dut (
    .clk(clk), .rst(rst), .vi(vi), .vci(vci), .pkti(pkti), .full(full),
    .ack(ack), .req(req), .vo(vo), .pkto(pkto), .vco(vco), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec  = 0;
  int nMiss = 0;
  int cyc   = 0;

  // Packet-level model: one queue per VC and the packet in flight.
  logic [FLITW-1:0] q0[$];
  logic [FLITW-1:0] q1[$];
  bit               mBusy;
  int               mCur;
  int               mLast;
  logic [NPORT-1:0] mReq;
  int               mVco;
  bit               mErr;

  logic             lastVo;
  logic [FLITW-1:0] lastPkto;
  int               recVc[$];
  int               recCyc[$];
  logic [FLITW-1:0] recFlit[$];

  function automatic logic [FLITW-1:0] mk(input logic [1:0] t, input int d, input logic [DATAW-1:0] p);
    logic [DSTW-1:0] dd;
    dd = DSTW'(d);
    return {t, dd, p};
  endfunction

  function automatic int qsize(input int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [FLITW-1:0] qfront(input int v);
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int v);
    if (v == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int v, input logic [FLITW-1:0] f);
    if (v == 0) q0.push_back(f);
    else        q1.push_back(f);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nVec++;
    if (act !== expv) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance both.
  task automatic applyStimulus(input logic iVi, input int iVci, input logic [FLITW-1:0] iPkt,
                               input logic iAck, input logic iRst);
    logic             eVo;
    logic [FLITW-1:0] ePkto;
    logic [NVC-1:0]   eFull;
    logic [FLITW-1:0] f;
    logic [1:0]       t;
    int               d;
    bit               blocked;
    bit               picked;
    int               pv;
    vi   = iVi;
    vci  = VCW'(iVci);
    pkti = iPkt;
    ack  = iAck;
    rst  = iRst;
    #1;
    eVo   = mBusy && iAck && (qsize(mCur) > 0);
    ePkto = eVo ? qfront(mCur) : '0;
    for (int v = 0; v < NVC; v++) eFull[v] = (qsize(v) == DEPTH);
    checkOutput("full", 64'(full), 64'(eFull));
    checkOutput("req",  64'(req),  64'(mReq));
    checkOutput("vo",   64'(vo),   64'(eVo));
    checkOutput("pkto", 64'(pkto), 64'(ePkto));
    checkOutput("vco",  64'(vco),  64'(mVco));
    checkOutput("err",  64'(err),  64'(mErr));
    lastVo   = vo;
    lastPkto = pkto;
    if (vo) begin
      recVc.push_back(int'(vco));
      recCyc.push_back(cyc);
      recFlit.push_back(pkto);
    end
    if (iRst) begin
      q0.delete();
      q1.delete();
      mBusy = 0; mCur = 0; mLast = NVC - 1; mReq = '0; mVco = 0; mErr = 0;
    end else begin
      blocked = iVi && ((iVci >= NVC) || (qsize(iVci) == DEPTH));
      if (mBusy) begin
        if (eVo) begin
          f = qfront(mCur);
          qpop(mCur);
          t = f[FLITW-1 -: 2];
          if (t == 2'b10 || t == 2'b11) begin
            mBusy = 0;
            mReq  = '0;
          end
        end
      end else begin
        picked = 0;
        pv     = 0;
        for (int k = 1; k <= NVC; k++) begin
          if (!picked && qsize((mLast + k) % NVC) > 0) begin
            picked = 1;
            pv     = (mLast + k) % NVC;
          end
        end
        if (picked) begin
          mLast = pv;
          mVco  = pv;
          f = qfront(pv);
          t = f[FLITW-1 -: 2];
          d = int'(f[DATAW +: DSTW]);
          if ((t == 2'b01 || t == 2'b11) && d < NPORT) begin
            mBusy = 1;
            mCur  = pv;
            mReq  = NPORT'(1) << d;
          end else begin
            qpop(pv);
            mErr = 1;
          end
        end
      end
      if (iVi) begin
        if (blocked) mErr = 1;
        else         qpush(iVci, iPkt);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clearRec();
    recVc.delete();
    recCyc.delete();
    recFlit.delete();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0);
  endtask

  logic [FLITW-1:0] f1;
  logic [FLITW-1:0] pk[4];
  int expOrder[4] = '{0, 1, 0, 1};

  initial begin
    vi = 0; vci = '0; pkti = '0; ack = 0; rst = 1;
    mBusy = 0; mCur = 0; mLast = NVC - 1; mReq = '0; mVco = 0; mErr = 0;
    lastVo = 0; lastPkto = '0;
    @(negedge clk);
    doReset();
    checkOutput("reset req", 64'(req), 64'h0);
    checkOutput("reset full", 64'(full), 64'h0);
    checkOutput("reset err", 64'(err), 64'h0);
    checkOutput("reset vco", 64'(vco), 64'h0);

    // Single-flit packet to port 2.
    f1 = mk(2'b11, 2, 32'hDEAD_0001);
    applyStimulus(1, 0, f1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t1 req", 64'(req), 64'h04);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t1 vo", 64'(lastVo), 64'h1);
    checkOutput("t1 pkto", 64'(lastPkto), 64'(f1));
    checkOutput("t1 req clr", 64'(req), 64'h0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t1 no vo", 64'(lastVo), 64'h0);

    // 4-flit packet on VC1 to port 4, stalled by ack.
    doReset();
    pk[0] = mk(2'b01, 4, 32'hA1); pk[1] = mk(2'b00, 4, 32'hA2);
    pk[2] = mk(2'b00, 4, 32'hA3); pk[3] = mk(2'b10, 4, 32'hA4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, pk[i], 0, 0);
    clearRec();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t2 req held", 64'(req), 64'h10);
    checkOutput("t2 stall vo", 64'(recVc.size()), 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t2 count", 64'(recFlit.size()), 64'h4);
    for (int i = 0; i < recFlit.size() && i < 4; i++) begin
      checkOutput("t2 order", 64'(recFlit[i]), 64'(pk[i]));
      checkOutput("t2 vco", 64'(recVc[i]), 64'h1);
      if (i > 0) checkOutput("t2 back2back", 64'(recCyc[i] - recCyc[i-1]), 64'h1);
    end

    // Fairness between two VCs with single-flit packets.
    doReset();
    applyStimulus(1, 0, mk(2'b11, 0, 32'hF0), 0, 0);
    applyStimulus(1, 1, mk(2'b11, 1, 32'hF1), 0, 0);
    applyStimulus(1, 0, mk(2'b11, 2, 32'hF2), 0, 0);
    applyStimulus(1, 1, mk(2'b11, 3, 32'hF3), 0, 0);
    clearRec();
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t3 count", 64'(recVc.size()), 64'h4);
    for (int i = 0; i < recVc.size() && i < 4; i++) begin
      checkOutput("t3 order", 64'(recVc[i]), 64'(expOrder[i]));
      if (i > 0) checkOutput("t3 bubble", 64'(recCyc[i] - recCyc[i-1]), 64'h2);
    end

    // Overflow of VC0.
    doReset();
    pk[0] = mk(2'b01, 0, 32'hB1); pk[1] = mk(2'b00, 0, 32'hB2);
    pk[2] = mk(2'b00, 0, 32'hB3); pk[3] = mk(2'b10, 0, 32'hB4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, pk[i], 0, 0);
    checkOutput("t4 full", 64'(full), 64'h1);
    checkOutput("t4 err before", 64'(err), 64'h0);
    applyStimulus(1, 0, mk(2'b00, 0, 32'hB5), 0, 0);
    checkOutput("t4 err", 64'(err), 64'h1);
    clearRec();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t4 count", 64'(recFlit.size()), 64'h4);
    for (int i = 0; i < recFlit.size() && i < 4; i++)
      checkOutput("t4 drain", 64'(recFlit[i]), 64'(pk[i]));
    checkOutput("t4 full clr", 64'(full), 64'h0);

    // Protocol errors: leading body flit, then an out-of-range destination.
    doReset();
    applyStimulus(1, 0, mk(2'b00, 1, 32'hE1), 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t5 body err", 64'(err), 64'h1);
    checkOutput("t5 body req", 64'(req), 64'h0);
    doReset();
    applyStimulus(1, 0, mk(2'b01, 7, 32'hE2), 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t5 dst err", 64'(err), 64'h1);
    checkOutput("t5 dst req", 64'(req), 64'h0);

    // Reset in the middle of a packet.
    doReset();
    pk[0] = mk(2'b01, 1, 32'hC1); pk[1] = mk(2'b00, 1, 32'hC2);
    pk[2] = mk(2'b00, 1, 32'hC3); pk[3] = mk(2'b10, 1, 32'hC4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, pk[i], 0, 0);
    applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t6 second flit", 64'(lastPkto), 64'(pk[1]));
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t6 req", 64'(req), 64'h0);
    checkOutput("t6 full", 64'(full), 64'h0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t6 vo", 64'(lastVo), 64'h0);
    f1 = mk(2'b11, 3, 32'hC0);
    applyStimulus(1, 0, f1, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t6 new req", 64'(req), 64'h08);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t6 new vo", 64'(lastVo), 64'h1);
    checkOutput("t6 new pkto", 64'(lastPkto), 64'(f1));
    applyStimulus(0, 0, '0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
